alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Width-generic successor to the single-cycle 4-bit ALU.
- Keeps the 14 existing opcodes and adds iterative unsigned multiply (shift-add) and divide (restoring).
- Adds valid/ready handshakes on both input and output, so it can sit between an operand register file and a writeback stage that may stall.
- Rotates and shifts are correct for any WIDTH.

Parameters:
- WIDTH, 8, operand and result width in bits; must be >= 2.
- CNT_W, $clog2(WIDTH+1), width of the iteration counter; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  command present.
- in_ready  out  1  block can accept a command.
- opcode  in  4  operation select.
- A  in  WIDTH  operand A (unsigned).
- B  in  WIDTH  operand B (unsigned).
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out  out  WIDTH  result: low product for MUL, quotient for DIV.
- out_rem  out  WIDTH  remainder for DIV, high product half for MUL, 0 otherwise.
- overflow  out  1  carry out (ADD/INC); high product half nonzero (MUL).
- underflow  out  1  borrow (SUB/DEC).
- zero  out  1  out == 0.
- div_err  out  1  DIV with B == 0.

Behaviour:
- Clock and reset: one clock, clk. reset_n is synchronous and active-low: on a rising edge with reset_n=0, all registers clear.
  - Reset values: state=IDLE, out=0, out_rem=0, all flags 0, out_valid=0, counter=0.
  - in_ready is 1 after reset is released.
  - Reset mid-operation aborts a MUL/DIV with no output.
- Opcodes:
  - 0 ADD, 1 SUB, 2 INC, 3 DEC, 4 ZERO.
  - 5 AND, 6 OR, 7 XOR, 8 INV(A), 9 NOR.
  - 10 SL, 11 SR (logical, 1 bit, zero fill).
  - 12 RL = {A[WIDTH-2:0],A[WIDTH-1]}, 13 RR = {A[0],A[WIDTH-1:1]}.
  - 14 MUL, 15 DIV.
- Arithmetic:
  - Computed at WIDTH+1 bits; bit WIDTH is carry (ADD/INC) or borrow (SUB/DEC). The low WIDTH bits wrap modulo 2^WIDTH.
  - Flags not defined for an opcode are 0.
  - zero is computed on out in every mode.
- State machine: IDLE, BUSY, DONE. in_ready = (state==IDLE). out_valid = (state==DONE).
- Accept: a command is accepted on an edge where in_valid && in_ready. A, B and opcode are captured; later input changes are ignored.
- IDLE, opcode 0-13: the result and flags are registered on the accept edge and the block goes to DONE. out_valid is visible the cycle after acceptance (latency 1).
- IDLE, MUL: load multiplicand, multiplier and a 2*WIDTH accumulator; counter=WIDTH; go to BUSY.
  - Each BUSY cycle: if multiplier LSB is set, add multiplicand<<i; shift; decrement counter.
  - When counter reaches 0: go to DONE with out = low half and out_rem = high half. overflow = |high half.
  - out_valid rises WIDTH+1 cycles after acceptance.
- IDLE, DIV with B != 0: restoring division, one quotient bit per BUSY cycle for WIDTH cycles, MSB first. DONE: out = A/B, out_rem = A%B. Same latency as MUL.
- IDLE, DIV with B == 0: no BUSY phase. Go directly to DONE with out = all ones, out_rem = A, div_err=1. Latency 1.
- DONE:
  - Outputs and flags hold stable while out_ready=0.
  - On an edge with out_ready=1, go to IDLE and drop out_valid. in_ready rises the same cycle, so the next accept is possible one cycle after the handshake. No bypass of DONE to a new command.
  - Results remain readable on out after out_valid falls; they are not cleared until the next command's result or reset.
- BUSY: in_ready=0. in_valid is ignored; the command must be held by the producer.
- Undefined encodings: none; all 16 opcodes are defined.

Test Plan:
- WIDTH=8. Reset: hold reset_n=0 for 2 cycles -> out=0, all flags 0, out_valid=0; in_ready=1 after release.
- ADD A=8'hF0, B=8'h20 -> next cycle out_valid=1, out=8'h10, overflow=1, zero=0.
- SUB A=8'h05, B=8'h05 -> out=0, zero=1, underflow=0.
- DEC A=0 -> out=8'hFF, underflow=1.
- RL A=8'h81 -> out=8'h03. RR A=8'h01 -> out=8'h80.
- MUL A=8'd200, B=8'd3 -> in_ready=0 for 8 cycles; out_valid at accept+9; out=8'h58, out_rem=8'h02, overflow=1.
- DIV A=8'd100, B=8'd7 -> out=8'd14, out_rem=8'd2 at accept+9.
- DIV A=8'd9, B=0 -> at accept+1: out=8'hFF, out_rem=8'd9, div_err=1.
- Backpressure: hold out_ready=0 for 5 cycles after an XOR -> out stable, out_valid=1, in_ready=0. Raise out_ready -> next cycle out_valid=0, in_ready=1.
- Reset mid-MUL: drive reset_n=0 at accept+4 -> no out_valid; state=IDLE; out=0.

Source files
------------

// File: rtl/alu_seq.sv
// Width-generic ALU with valid/ready handshakes on both sides.
// MUL (shift-add) and DIV (restoring) iterate one bit per cycle; all other opcodes take a single cycle.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_rem,
  output logic             overflow,
  output logic             underflow,
  output logic             zero,
  output logic             div_err
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH:0] ONE_X = (WIDTH+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_is_div;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_dq;
  logic [WIDTH-1:0]     r_drem;
  logic [WIDTH-1:0]     r_dvsr;
  logic [WIDTH-1:0]     r_out;
  logic [WIDTH-1:0]     r_rem;
  logic                 r_ovf;
  logic                 r_udf;
  logic                 r_zero;
  logic                 r_div_err;

  logic                 w_accept;
  logic                 w_last;
  logic [WIDTH:0]       w_ext;
  logic [WIDTH-1:0]     w_res;
  logic                 w_ovf;
  logic                 w_udf;
  logic [2*WIDTH-1:0]   w_acc_nxt;
  logic [WIDTH:0]       w_trial;
  logic [WIDTH:0]       w_diff;
  logic                 w_ge;
  logic [WIDTH-1:0]     w_rem_nxt;
  logic [WIDTH-1:0]     w_q_nxt;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_cnt == CNT_W'(1));
  assign out       = r_out;
  assign out_rem   = r_rem;
  assign overflow  = r_ovf;
  assign underflow = r_udf;
  assign zero      = r_zero;
  assign div_err   = r_div_err;

  // Single-cycle operations, evaluated at WIDTH+1 bits so bit WIDTH is carry/borrow
  always_comb begin
    w_ext = '0;
    w_res = '0;
    w_ovf = 1'b0;
    w_udf = 1'b0;
    case (opcode)
      4'd0:  begin w_ext = {1'b0, A} + {1'b0, B}; w_res = w_ext[WIDTH-1:0]; w_ovf = w_ext[WIDTH]; end
      4'd1:  begin w_ext = {1'b0, A} - {1'b0, B}; w_res = w_ext[WIDTH-1:0]; w_udf = w_ext[WIDTH]; end
      4'd2:  begin w_ext = {1'b0, A} + ONE_X;     w_res = w_ext[WIDTH-1:0]; w_ovf = w_ext[WIDTH]; end
      4'd3:  begin w_ext = {1'b0, A} - ONE_X;     w_res = w_ext[WIDTH-1:0]; w_udf = w_ext[WIDTH]; end
      4'd4:  w_res = '0;
      4'd5:  w_res = A & B;
      4'd6:  w_res = A | B;
      4'd7:  w_res = A ^ B;
      4'd8:  w_res = ~A;
      4'd9:  w_res = ~(A | B);
      4'd10: w_res = {A[WIDTH-2:0], 1'b0};
      4'd11: w_res = {1'b0, A[WIDTH-1:1]};
      4'd12: w_res = {A[WIDTH-2:0], A[WIDTH-1]};
      4'd13: w_res = {A[0], A[WIDTH-1:1]};
      default: w_res = '0;
    endcase
  end

  // One shift-add step and one restoring-division step per BUSY cycle
  always_comb begin
    w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
    w_trial   = {r_drem, r_dq[WIDTH-1]};
    w_diff    = w_trial - {1'b0, r_dvsr};
    w_ge      = ~w_diff[WIDTH];
    w_rem_nxt = w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
    w_q_nxt   = {r_dq[WIDTH-2:0], w_ge};
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept)
                w_state_nxt = ((opcode == 4'd14) || (opcode == 4'd15 && B != '0)) ? S_BUSY : S_DONE;
      S_BUSY: if (w_last) w_state_nxt = S_DONE;
      S_DONE: if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_dq      <= '0;
      r_drem    <= '0;
      r_dvsr    <= '0;
      r_out     <= '0;
      r_rem     <= '0;
      r_ovf     <= 1'b0;
      r_udf     <= 1'b0;
      r_zero    <= 1'b0;
      r_div_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          if (opcode == 4'd14) begin
            r_mcand  <= {{WIDTH{1'b0}}, A};
            r_mplier <= B;
            r_acc    <= '0;
            r_cnt    <= CNT_W'(WIDTH);
            r_is_div <= 1'b0;
          end else if (opcode == 4'd15 && B != '0) begin
            r_dq     <= A;
            r_drem   <= '0;
            r_dvsr   <= B;
            r_cnt    <= CNT_W'(WIDTH);
            r_is_div <= 1'b1;
          end else if (opcode == 4'd15) begin
            r_out     <= '1;
            r_rem     <= A;
            r_ovf     <= 1'b0;
            r_udf     <= 1'b0;
            r_zero    <= 1'b0;
            r_div_err <= 1'b1;
          end else begin
            r_out     <= w_res;
            r_rem     <= '0;
            r_ovf     <= w_ovf;
            r_udf     <= w_udf;
            r_zero    <= (w_res == '0);
            r_div_err <= 1'b0;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (!r_is_div) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (w_last) begin
              r_out     <= w_acc_nxt[WIDTH-1:0];
              r_rem     <= w_acc_nxt[2*WIDTH-1:WIDTH];
              r_ovf     <= |w_acc_nxt[2*WIDTH-1:WIDTH];
              r_udf     <= 1'b0;
              r_zero    <= (w_acc_nxt[WIDTH-1:0] == '0);
              r_div_err <= 1'b0;
            end
          end else begin
            r_dq   <= w_q_nxt;
            r_drem <= w_rem_nxt;
            if (w_last) begin
              r_out     <= w_q_nxt;
              r_rem     <= w_rem_nxt;
              r_ovf     <= 1'b0;
              r_udf     <= 1'b0;
              r_zero    <= (w_q_nxt == '0);
              r_div_err <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8; expected values are hand-computed constants.
module tb_alu_seq;

  logic       clk;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] opcode;
  logic [7:0] A;
  logic [7:0] B;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic [7:0] out_rem;
  logic       overflow;
  logic       underflow;
  logic       zero;
  logic       div_err;

  int errs   = 0;
  int checks = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .out_rem(out_rem), .overflow(overflow), .underflow(underflow),
    .zero(zero), .div_err(div_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a command for one edge; returns 1 time unit after the accept edge
  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1;
    opcode   = op;
    A        = a;
    B        = b;
    step();
    in_valid = 1'b0;
    A        = 8'h00;
    B        = 8'h00;
  endtask

  task automatic ack();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    int n;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    opcode    = 4'd0;
    A         = 8'h00;
    B         = 8'h00;
    step();
    step();
    chk("rst_out", out, 8'h00);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_flags", {overflow, underflow, zero, div_err}, 4'b0000);
    reset_n = 1'b1;
    step();
    chk("rst_in_ready", in_ready, 1'b1);

    issue(4'd0, 8'hF0, 8'h20);
    chk("add_valid", out_valid, 1'b1);
    chk("add_out", out, 8'h10);
    chk("add_ovf", overflow, 1'b1);
    chk("add_zero", zero, 1'b0);
    ack();
    chk("add_ack_valid", out_valid, 1'b0);
    chk("add_ack_ready", in_ready, 1'b1);

    issue(4'd1, 8'h05, 8'h05);
    chk("sub_out", out, 8'h00);
    chk("sub_zero", zero, 1'b1);
    chk("sub_udf", underflow, 1'b0);
    ack();

    issue(4'd3, 8'h00, 8'h00);
    chk("dec_out", out, 8'hFF);
    chk("dec_udf", underflow, 1'b1);
    chk("dec_zero", zero, 1'b0);
    ack();

    issue(4'd12, 8'h81, 8'h00);
    chk("rl_out", out, 8'h03);
    ack();
    issue(4'd13, 8'h01, 8'h00);
    chk("rr_out", out, 8'h80);
    ack();
    issue(4'd10, 8'h81, 8'h00);
    chk("sl_out", out, 8'h02);
    ack();
    issue(4'd11, 8'h81, 8'h00);
    chk("sr_out", out, 8'h40);
    ack();

    issue(4'd14, 8'd200, 8'd3);
    for (int i = 0; i < 8; i++) begin
      chk("mul_busy_ready", in_ready, 1'b0);
      chk("mul_busy_valid", out_valid, 1'b0);
      step();
    end
    chk("mul_valid", out_valid, 1'b1);
    chk("mul_out", out, 8'h58);
    chk("mul_rem", out_rem, 8'h02);
    chk("mul_ovf", overflow, 1'b1);
    ack();

    issue(4'd15, 8'd100, 8'd7);
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk("div_latency", n, 8);
    chk("div_out", out, 8'd14);
    chk("div_rem", out_rem, 8'd2);
    chk("div_err_clear", div_err, 1'b0);
    ack();

    issue(4'd15, 8'd9, 8'd0);
    chk("div0_valid", out_valid, 1'b1);
    chk("div0_out", out, 8'hFF);
    chk("div0_rem", out_rem, 8'd9);
    chk("div0_err", div_err, 1'b1);
    ack();

    issue(4'd7, 8'h0F, 8'hFF);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out", out, 8'hF0);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_ready", in_ready, 1'b0);
      step();
    end
    chk("xor_rem", out_rem, 8'h00);
    chk("xor_err", div_err, 1'b0);
    ack();
    chk("bp_rel_valid", out_valid, 1'b0);
    chk("bp_rel_ready", in_ready, 1'b1);
    chk("bp_hold_out", out, 8'hF0);

    issue(4'd14, 8'd200, 8'd3);
    step();
    step();
    step();
    reset_n = 1'b0;
    step();
    chk("mrst_valid", out_valid, 1'b0);
    chk("mrst_ready", in_ready, 1'b1);
    chk("mrst_out", out, 8'h00);
    reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) n++;
      step();
    end
    chk("mrst_no_result", n, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
